// File: rtl/dsram_arbiter.sv
// dsram_arbiter
// Shares one single-port data SRAM between the execute stage (es) and a
// DMA/debug requester. Grants are combinational so a lone requester sees
// no added latency. es normally wins, but a DMA request that has been
// denied STARVE_LIMIT cycles in a row takes priority. Read data is routed
// back to whichever side owned the read one cycle earlier.
module dsram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        es_req,
    input  logic [3:0]  es_wen,
    input  logic [31:0] es_addr,
    input  logic [31:0] es_wdata,
    output logic        es_gnt,
    output logic        es_rvalid,
    output logic [31:0] es_rdata,

    input  logic        dma_req,
    input  logic [3:0]  dma_wen,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,

    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);

    // A limit of 0 still needs a 1-bit counter to stay a legal vector.
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        OWNER_ES  = 1'b0,
        OWNER_DMA = 1'b1
    } owner_t;

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic             rd_pend;
    owner_t           rd_owner;
    logic             rd_grant;

    // Saturating increment: holds at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_MAX) begin
            return CNT_MAX;
        end
        return v + 1'b1;
    endfunction

    assign starved = (starve_cnt == CNT_MAX);

    // Grant selection: es first unless DMA has been starved; nothing while in reset.
    always_comb begin
        es_gnt  = 1'b0;
        dma_gnt = 1'b0;
        if (resetn) begin
            if (dma_req && (starved || !es_req)) begin
                dma_gnt = 1'b1;
            end else if (es_req) begin
                es_gnt = 1'b1;
            end
        end
    end

    // SRAM port mux: winner's payload on a grant, all zero when idle.
    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        if (es_gnt) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = es_wen;
            data_sram_addr  = es_addr;
            data_sram_wdata = es_wdata;
        end else if (dma_gnt) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = dma_wen;
            data_sram_addr  = dma_addr;
            data_sram_wdata = dma_wdata;
        end
    end

    assign rd_grant = data_sram_en && (data_sram_wen == 4'b0000);

    // Count consecutive denied DMA cycles; any DMA grant or idle DMA clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (dma_req && !dma_gnt) begin
            starve_cnt <= sat_inc(starve_cnt);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Remember whether a read was issued this cycle and who issued it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWNER_ES;
        end else begin
            rd_pend <= rd_grant;
            if (rd_grant) begin
                rd_owner <= dma_gnt ? OWNER_DMA : OWNER_ES;
            end
        end
    end

    // Steer the SRAM return to its owner; rdata is forced to 0 without rvalid.
    always_comb begin
        es_rvalid  = rd_pend && (rd_owner == OWNER_ES);
        dma_rvalid = rd_pend && (rd_owner == OWNER_DMA);
        es_rdata   = es_rvalid  ? data_sram_rdata : 32'h0;
        dma_rdata  = dma_rvalid ? data_sram_rdata : 32'h0;
    end

endmodule

// File: tb/tb_dsram_arbiter.sv
// Directed testbench for dsram_arbiter (STARVE_LIMIT = 4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dsram_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        es_req = 1'b0;
    logic [3:0]  es_wen = 4'h0;
    logic [31:0] es_addr = 32'h0;
    logic [31:0] es_wdata = 32'h0;
    logic        es_gnt;
    logic        es_rvalid;
    logic [31:0] es_rdata;
    logic        dma_req = 1'b0;
    logic [3:0]  dma_wen = 4'h0;
    logic [31:0] dma_addr = 32'h0;
    logic [31:0] dma_wdata = 32'h0;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata = 32'h0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dsram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .es_req          (es_req),
        .es_wen          (es_wen),
        .es_addr         (es_addr),
        .es_wdata        (es_wdata),
        .es_gnt          (es_gnt),
        .es_rvalid       (es_rvalid),
        .es_rdata        (es_rdata),
        .dma_req         (dma_req),
        .dma_wen         (dma_wen),
        .dma_addr        (dma_addr),
        .dma_wdata       (dma_wdata),
        .dma_gnt         (dma_gnt),
        .dma_rvalid      (dma_rvalid),
        .dma_rdata       (dma_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: read data appears one cycle after a read is enabled and
    // otherwise holds its last value. 0x100 holds 0xDEADBEEF, any other
    // address reads back as {16'hC0DE, addr[15:0]}.
    always @(posedge clk) begin
        if (data_sram_en && data_sram_wen == 4'b0000) begin
            data_sram_rdata <= (data_sram_addr == 32'h100) ? 32'hDEADBEEF
                                                           : {16'hC0DE, data_sram_addr[15:0]};
        end
    end

    task automatic set_es(input logic req, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata);
        es_req = req; es_wen = wen; es_addr = addr; es_wdata = wdata;
    endtask

    task automatic set_dma(input logic req, input logic [3:0] wen,
                           input logic [31:0] addr, input logic [31:0] wdata);
        dma_req = req; dma_wen = wen; dma_addr = addr; dma_wdata = wdata;
    endtask

    task automatic test_reset;
        set_es(1'b1, 4'h0, 32'h100, 32'h0);
        set_dma(1'b1, 4'h0, 32'h200, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total_cnt++; if (es_gnt !== 1'b0) $display("FAIL rst_es_gnt: actual=%b required=0", es_gnt); else pass_cnt++;
        total_cnt++; if (dma_gnt !== 1'b0) $display("FAIL rst_dma_gnt: actual=%b required=0", dma_gnt); else pass_cnt++;
        total_cnt++; if (data_sram_en !== 1'b0) $display("FAIL rst_sram_en: actual=%b required=0", data_sram_en); else pass_cnt++;
        total_cnt++; if (es_rvalid !== 1'b0 || dma_rvalid !== 1'b0) $display("FAIL rst_rvalid: actual=%b%b required=00", es_rvalid, dma_rvalid); else pass_cnt++;
        total_cnt++; if (es_rdata !== 32'h0 || dma_rdata !== 32'h0) $display("FAIL rst_rdata: actual=%h/%h required=0/0", es_rdata, dma_rdata); else pass_cnt++;
        total_cnt++; if (dut.starve_cnt !== 3'd0) $display("FAIL rst_starve_cnt: actual=%0d required=0", dut.starve_cnt); else pass_cnt++;
        set_es(1'b0, 4'h0, 32'h0, 32'h0);
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;
    endtask

    task automatic test_lone_es_read;
        // First cycle out of reset: grant must be available immediately.
        @(negedge clk);
        set_es(1'b1, 4'h0, 32'h100, 32'h0);
        #1;
        total_cnt++; if (es_gnt !== 1'b1) $display("FAIL esrd_gnt: actual=%b required=1", es_gnt); else pass_cnt++;
        total_cnt++; if (dma_gnt !== 1'b0) $display("FAIL esrd_dma_gnt: actual=%b required=0", dma_gnt); else pass_cnt++;
        total_cnt++; if (data_sram_en !== 1'b1) $display("FAIL esrd_en: actual=%b required=1", data_sram_en); else pass_cnt++;
        total_cnt++; if (data_sram_addr !== 32'h100) $display("FAIL esrd_addr: actual=%h required=00000100", data_sram_addr); else pass_cnt++;
        total_cnt++; if (data_sram_wen !== 4'h0) $display("FAIL esrd_wen: actual=%h required=0", data_sram_wen); else pass_cnt++;
        @(negedge clk);
        set_es(1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        total_cnt++; if (es_rvalid !== 1'b1) $display("FAIL esrd_rvalid: actual=%b required=1", es_rvalid); else pass_cnt++;
        total_cnt++; if (es_rdata !== 32'hDEADBEEF) $display("FAIL esrd_rdata: actual=%h required=deadbeef", es_rdata); else pass_cnt++;
        total_cnt++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0) $display("FAIL esrd_dma_rv: actual=%b/%h required=0/0", dma_rvalid, dma_rdata); else pass_cnt++;
        total_cnt++; if (data_sram_en !== 1'b0 || data_sram_addr !== 32'h0 || data_sram_wdata !== 32'h0) $display("FAIL esrd_idle_port: actual=%b/%h/%h required=0/0/0", data_sram_en, data_sram_addr, data_sram_wdata); else pass_cnt++;
        @(negedge clk); #1;
        // SRAM still holds DEADBEEF here, so rdata must be masked to zero.
        total_cnt++; if (es_rvalid !== 1'b0 || es_rdata !== 32'h0) $display("FAIL esrd_after: actual=%b/%h required=0/0", es_rvalid, es_rdata); else pass_cnt++;
    endtask

    task automatic test_lone_dma_write;
        @(negedge clk);
        set_dma(1'b1, 4'b0011, 32'h40, 32'h1234);
        #1;
        total_cnt++; if (dma_gnt !== 1'b1) $display("FAIL dmawr_gnt: actual=%b required=1", dma_gnt); else pass_cnt++;
        total_cnt++; if (es_gnt !== 1'b0) $display("FAIL dmawr_es_gnt: actual=%b required=0", es_gnt); else pass_cnt++;
        total_cnt++; if (data_sram_wen !== 4'b0011) $display("FAIL dmawr_wen: actual=%h required=3", data_sram_wen); else pass_cnt++;
        total_cnt++; if (data_sram_addr !== 32'h40) $display("FAIL dmawr_addr: actual=%h required=00000040", data_sram_addr); else pass_cnt++;
        total_cnt++; if (data_sram_wdata !== 32'h1234) $display("FAIL dmawr_wdata: actual=%h required=00001234", data_sram_wdata); else pass_cnt++;
        total_cnt++; if (data_sram_en !== 1'b1) $display("FAIL dmawr_en: actual=%b required=1", data_sram_en); else pass_cnt++;
        @(negedge clk);
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        total_cnt++; if (es_rvalid !== 1'b0 || dma_rvalid !== 1'b0) $display("FAIL dmawr_rvalid: actual=%b%b required=00", es_rvalid, dma_rvalid); else pass_cnt++;
    endtask

    task automatic test_starvation;
        logic       exp_dma;
        logic [2:0] exp_cnt;
        @(negedge clk);
        set_es(1'b1, 4'hF, 32'h200, 32'hAAAA0000);
        set_dma(1'b1, 4'h1, 32'h300, 32'hBBBB0000);
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_dma = (c == 4);
            exp_cnt = (c <= 4) ? 3'(c) : 3'd0;
            total_cnt++; if (dma_gnt !== exp_dma) $display("FAIL starve_dma_gnt_c%0d: actual=%b required=%b", c, dma_gnt, exp_dma); else pass_cnt++;
            total_cnt++; if (es_gnt !== !exp_dma) $display("FAIL starve_es_gnt_c%0d: actual=%b required=%b", c, es_gnt, !exp_dma); else pass_cnt++;
            total_cnt++; if (data_sram_addr !== (exp_dma ? 32'h300 : 32'h200)) $display("FAIL starve_addr_c%0d: actual=%h", c, data_sram_addr); else pass_cnt++;
            total_cnt++; if (dut.starve_cnt !== exp_cnt) $display("FAIL starve_cnt_c%0d: actual=%0d required=%0d", c, dut.starve_cnt, exp_cnt); else pass_cnt++;
            @(negedge clk);
        end
        set_es(1'b0, 4'h0, 32'h0, 32'h0);
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        set_es(1'b1, 4'h0, 32'h10, 32'h0);
        #1;
        total_cnt++; if (es_gnt !== 1'b1 || data_sram_addr !== 32'h10) $display("FAIL b2b_es_gnt: actual=%b/%h required=1/00000010", es_gnt, data_sram_addr); else pass_cnt++;
        @(negedge clk);
        set_es(1'b0, 4'h0, 32'h0, 32'h0);
        set_dma(1'b1, 4'h0, 32'h20, 32'h0);
        #1;
        total_cnt++; if (dma_gnt !== 1'b1 || data_sram_addr !== 32'h20) $display("FAIL b2b_dma_gnt: actual=%b/%h required=1/00000020", dma_gnt, data_sram_addr); else pass_cnt++;
        total_cnt++; if (es_rvalid !== 1'b1 || es_rdata !== 32'hC0DE0010) $display("FAIL b2b_es_ret: actual=%b/%h required=1/c0de0010", es_rvalid, es_rdata); else pass_cnt++;
        total_cnt++; if (dma_rvalid !== 1'b0) $display("FAIL b2b_dma_early: actual=%b required=0", dma_rvalid); else pass_cnt++;
        @(negedge clk);
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        total_cnt++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hC0DE0020) $display("FAIL b2b_dma_ret: actual=%b/%h required=1/c0de0020", dma_rvalid, dma_rdata); else pass_cnt++;
        total_cnt++; if (es_rvalid !== 1'b0 || es_rdata !== 32'h0) $display("FAIL b2b_es_late: actual=%b/%h required=0/0", es_rvalid, es_rdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        set_es(1'b1, 4'h0, 32'h100, 32'h0);
        set_dma(1'b1, 4'hF, 32'h300, 32'h5555);
        @(posedge clk); #1;
        total_cnt++; if (es_rvalid !== 1'b1) $display("FAIL rmid_rvalid_pre: actual=%b required=1", es_rvalid); else pass_cnt++;
        total_cnt++; if (dut.starve_cnt !== 3'd1) $display("FAIL rmid_cnt_pre: actual=%0d required=1", dut.starve_cnt); else pass_cnt++;
        #1;
        resetn = 1'b0;
        #1;
        total_cnt++; if (es_rvalid !== 1'b0 || es_rdata !== 32'h0) $display("FAIL rmid_rvalid_drop: actual=%b/%h required=0/0", es_rvalid, es_rdata); else pass_cnt++;
        total_cnt++; if (es_gnt !== 1'b0 || dma_gnt !== 1'b0 || data_sram_en !== 1'b0) $display("FAIL rmid_gnt: actual=%b%b%b required=000", es_gnt, dma_gnt, data_sram_en); else pass_cnt++;
        total_cnt++; if (dut.starve_cnt !== 3'd0) $display("FAIL rmid_cnt: actual=%0d required=0", dut.starve_cnt); else pass_cnt++;
        @(negedge clk);
        set_es(1'b0, 4'h0, 32'h0, 32'h0);
        set_dma(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        total_cnt++; if (es_rvalid !== 1'b0 || dma_rvalid !== 1'b0) $display("FAIL rmid_stale0: actual=%b%b required=00", es_rvalid, dma_rvalid); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (es_rvalid !== 1'b0 || dma_rvalid !== 1'b0) $display("FAIL rmid_stale1: actual=%b%b required=00", es_rvalid, dma_rvalid); else pass_cnt++;
        total_cnt++; if (dut.starve_cnt !== 3'd0) $display("FAIL rmid_cnt_post: actual=%0d required=0", dut.starve_cnt); else pass_cnt++;
    endtask

    task automatic test_idle;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            total_cnt++; if (data_sram_en !== 1'b0 || data_sram_wen !== 4'h0) $display("FAIL idle_en_c%0d: actual=%b/%h required=0/0", c, data_sram_en, data_sram_wen); else pass_cnt++;
            total_cnt++; if (es_gnt !== 1'b0 || dma_gnt !== 1'b0) $display("FAIL idle_gnt_c%0d: actual=%b%b required=00", c, es_gnt, dma_gnt); else pass_cnt++;
            total_cnt++; if (es_rvalid !== 1'b0 || dma_rvalid !== 1'b0) $display("FAIL idle_rvalid_c%0d: actual=%b%b required=00", c, es_rvalid, dma_rvalid); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_lone_es_read;
        test_lone_dma_write;
        test_starvation;
        test_back_to_back;
        test_reset_mid;
        test_idle;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
